// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter for the bridge slave port. It holds the grant for defined-length bursts and locked sequences.
// It arbitrates round-robin by default. Defining ARB_FIXED_PRIORITY_EN switches to fixed priority (lowest index wins).
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MIDX_WIDTH     = 2,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                   hclk_i,
  input  logic                   hreset_i,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic [NUM_MASTERS-1:0] hlock_i,
  input  logic [1:0]             htrans_i,
  input  logic [2:0]             hburst_i,
  input  logic                   hready_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [MIDX_WIDTH-1:0]  hmaster_o,
  output logic                   hmastlock_o
);

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [4:0] INCR_CAP  = 5'(MAX_INCR_BEATS);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MIDX_WIDTH-1:0]  hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [4:0]             beat_cnt_q, beat_cnt_d;
  logic [4:0]             len_q, len_d;
  logic                   incr_q, incr_d;

  logic [MIDX_WIDTH-1:0]  grant_idx;
  logic [MIDX_WIDTH-1:0]  pick_idx;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] arb_grant;
  logic                   arb_lock;
  logic [4:0]             len_new;
  logic                   beat, nonseq, idle, do_arb;

  assign beat   = hready_i & htrans_i[1];
  assign nonseq = (htrans_i == TR_NONSEQ);
  assign idle   = (htrans_i == TR_IDLE);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) grant_idx = grant_idx | MIDX_WIDTH'(i);
  end

  always_comb begin
    case (hburst_i)
      3'd0:       len_new = 5'd1;
      3'd1:       len_new = INCR_CAP;
      3'd2, 3'd3: len_new = 5'd4;
      3'd4, 3'd5: len_new = 5'd8;
      default:    len_new = 5'd16;
    endcase
  end

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (hbusreq_i[i]) begin
        pick_valid = 1'b1;
        pick_idx   = MIDX_WIDTH'(i);
      end
  end
`else
  logic [MIDX_WIDTH-1:0] rr_q, rr_d;
  logic [MIDX_WIDTH-1:0] cand;

  // Scan from the far end so the candidate closest after rr_q is assigned last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = MIDX_WIDTH'((int'(rr_q) + i) % NUM_MASTERS);
      if (hbusreq_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`endif

  assign arb_grant = pick_valid ? (NUM_MASTERS'(1) << pick_idx) : NUM_MASTERS'(1);
  assign arb_lock  = pick_valid & hlock_i[pick_idx];

  // htrans_i/hburst_i are taken to belong to the currently granted master.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    beat_cnt_d  = beat_cnt_q;
    len_d       = len_q;
    incr_d      = incr_q;
    do_arb      = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_d        = rr_q;
`endif
    if (hready_i) begin
      hmaster_d   = grant_idx;
      hmastlock_d = hlock_i[grant_idx];
      case (state_q)
        ST_ARB: begin
          if (beat && nonseq && len_new > 5'd1) begin
            state_d    = ST_BURST;
            beat_cnt_d = 5'd1;
            len_d      = len_new;
            incr_d     = (hburst_i == HB_INCR);
          end else begin
            do_arb = 1'b1;
          end
        end
        ST_BURST: begin
          if (beat) begin
            if (nonseq) begin
              if (len_new == 5'd1) begin
                do_arb = 1'b1;
              end else begin
                beat_cnt_d = 5'd1;
                len_d      = len_new;
                incr_d     = (hburst_i == HB_INCR);
              end
            end else if (beat_cnt_q == len_q - 5'd1) begin
              do_arb = 1'b1;
            end else begin
              beat_cnt_d = (beat_cnt_q >= INCR_CAP) ? INCR_CAP : beat_cnt_q + 5'd1;
            end
          end else if (incr_q && idle) begin
            do_arb = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (idle && !hlock_i[grant_idx]) do_arb = 1'b1;
        end
        default: do_arb = 1'b1;
      endcase
      if (do_arb) begin
        grant_d    = arb_grant;
        beat_cnt_d = 5'd0;
        state_d    = arb_lock ? ST_LOCKED : ST_ARB;
`ifndef ARB_FIXED_PRIORITY_EN
        if (pick_valid) rr_d = pick_idx;
`endif
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q     <= ST_ARB;
      grant_q     <= NUM_MASTERS'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= 5'd0;
      len_q       <= 5'd0;
      incr_q      <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      incr_q      <= incr_d;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign hgrant_o    = grant_q;
  assign hmaster_o   = hmaster_q;
  assign hmastlock_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: expected grant/master/lock are queued per step and checked after the edge.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, WRAP16 = 3'd6;

  logic       hclk_i = 1'b0;
  logic       hreset_i = 1'b0;
  logic [3:0] hbusreq_i = '0;
  logic [3:0] hlock_i = '0;
  logic [1:0] htrans_i = IDLE;
  logic [2:0] hburst_i = SINGLE;
  logic       hready_i = 1'b1;
  logic [3:0] hgrant_o;
  logic [1:0] hmaster_o;
  logic       hmastlock_o;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .MIDX_WIDTH(2), .MAX_INCR_BEATS(16)) dut (
    .hclk_i(hclk_i), .hreset_i(hreset_i), .hbusreq_i(hbusreq_i), .hlock_i(hlock_i),
    .htrans_i(htrans_i), .hburst_i(hburst_i), .hready_i(hready_i),
    .hgrant_o(hgrant_o), .hmaster_o(hmaster_o), .hmastlock_o(hmastlock_o)
  );

  always #5 hclk_i = ~hclk_i;

  always @(negedge hclk_i) begin
    if (!hreset_i) begin
      vectors++;
      assert ($onehot(hgrant_o)) else begin
        miscompares++;
        $error("FAIL onehot grant obs=%b exp=one-hot", hgrant_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [3:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    e.g = eg; e.m = em; e.l = el;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    vectors++;
    assert (sb_q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard obs=empty exp=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors += 3;
      assert (hgrant_o === e.g) else begin
        miscompares++;
        $error("FAIL %s hgrant obs=%b exp=%b", tag, hgrant_o, e.g);
      end
      assert (hmaster_o === e.m) else begin
        miscompares++;
        $error("FAIL %s hmaster obs=%0d exp=%0d", tag, hmaster_o, e.m);
      end
      assert (hmastlock_o === e.l) else begin
        miscompares++;
        $error("FAIL %s hmastlock obs=%b exp=%b", tag, hmastlock_o, e.l);
      end
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                      input logic [2:0] burst, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] em, input logic el, input string tag);
    hbusreq_i = req; hlock_i = lock; htrans_i = trans; hburst_i = burst; hready_i = rdy;
    push_exp(eg, em, el);
    @(posedge hclk_i);
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset();
    hbusreq_i = '0; hlock_i = '0; htrans_i = IDLE; hburst_i = SINGLE; hready_i = 1'b1;
    hreset_i = 1'b1;
    #2;
    push_exp(4'b0001, 2'd0, 1'b0);
    compare_out("reset");
    @(posedge hclk_i);
    #1;
    hreset_i = 1'b0;
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] eg;
    logic [1:0] em;
    one = 4'b0001;
    #1;

    // 1: park on master 0
    do_reset();
    for (int k = 0; k < 10; k++) step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0, "park");

    // 2: all requesting, SINGLE beats
    do_reset();
    for (int k = 1; k <= 5; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      eg = 4'b0001; em = 2'd0;
`else
      eg = one << (k % 4); em = 2'((k - 1) % 4);
`endif
      step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, eg, em, 1'b0, "rotate");
    end

    // 3: M2 INCR8, M1 requests from beat 2
    do_reset();
    step(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0, "b3_grant");
    step(4'b0100, 4'b0000, NONSEQ, INCR8,  1'b1, 4'b0100, 2'd2, 1'b0, "b3_beat1");
    for (int k = 2; k <= 7; k++) step(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, 4'b0100, 2'd2, 1'b0, "b3_hold");
    step(4'b0110, 4'b0000, SEQ,    INCR8,  1'b1, 4'b0010, 2'd2, 1'b0, "b3_beat8");
    step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0, "b3_master");

    // 4: M3 INCR8 with a 3-cycle wait state at beat 4
    do_reset();
    step(4'b1000, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd0, 1'b0, "b4_grant");
    step(4'b1000, 4'b0000, NONSEQ, INCR8,  1'b1, 4'b1000, 2'd3, 1'b0, "b4_beat1");
    for (int k = 2; k <= 3; k++) step(4'b1001, 4'b0000, SEQ, INCR8, 1'b1, 4'b1000, 2'd3, 1'b0, "b4_hold");
    for (int k = 0; k < 3; k++) step(4'b1001, 4'b0000, SEQ, INCR8, 1'b0, 4'b1000, 2'd3, 1'b0, "b4_wait");
    for (int k = 4; k <= 7; k++) step(4'b1001, 4'b0000, SEQ, INCR8, 1'b1, 4'b1000, 2'd3, 1'b0, "b4_resume");
    step(4'b1001, 4'b0000, SEQ,    INCR8,  1'b1, 4'b0001, 2'd3, 1'b0, "b4_beat8");
    step(4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0, "b4_master");

    // 5: M1 locked sequence with M0/M2 requesting
    do_reset();
    step(4'b0010, 4'b0010, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, "lk_grant");
    for (int k = 0; k < 4; k++) step(4'b0111, 4'b0010, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1, "lk_hold");
`ifdef ARB_FIXED_PRIORITY_EN
    step(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd1, 1'b0, "lk_release");
    step(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0, "lk_next");
`else
    step(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0, "lk_release");
    step(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0, "lk_next");
`endif

    // 6: reset mid WRAP16
    do_reset();
    step(4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0, "rb_grant");
    step(4'b0100, 4'b0000, NONSEQ, WRAP16, 1'b1, 4'b0100, 2'd2, 1'b0, "rb_beat1");
    for (int k = 2; k <= 4; k++) step(4'b0110, 4'b0000, SEQ, WRAP16, 1'b1, 4'b0100, 2'd2, 1'b0, "rb_hold");
    hbusreq_i = 4'b0110; htrans_i = SEQ; hburst_i = WRAP16;
    #2;
    hreset_i = 1'b1;
    #1;
    push_exp(4'b0001, 2'd0, 1'b0);
    compare_out("rb_async");
    @(posedge hclk_i);
    #1;
    hreset_i = 1'b0;
    step(4'b1010, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, "rb_rearb");
    step(4'b1010, 4'b0000, NONSEQ, INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, "rb_newburst");
    step(4'b1010, 4'b0000, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, "rb_newhold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
